// File: rtl/theta_pkg.sv
// Shared types and helpers for the Keccak theta apply stage.
// State encodings, lane-grid geometry and the 1-bit lane rotate.
package theta_pkg;

    localparam int NLANE_DIM = 5;
    localparam int COORD_W   = 3;
    localparam int LANE_MAX  = 64;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Rotate the low w bits of lane left by one; bits at and above w stay 0.
    function automatic logic [LANE_MAX-1:0] rotl1(
        input logic [LANE_MAX-1:0] lane,
        input int unsigned         w
    );
        logic [LANE_MAX-1:0] ones;
        ones  = '1;
        rotl1 = ((lane << 1) | (lane >> (w - 1))) & ~(ones << w);
    endfunction

endpackage

// File: rtl/counter5.sv
// Mod-5 lane coordinate counter.
// prev/cur/nxt are all registered so the neighbour indices need no adder.
module counter5
    import theta_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   inc,
    output coord_t prev,
    output coord_t cur,
    output coord_t nxt,
    output logic   last
);

    localparam coord_t TOP = coord_t'(NLANE_DIM - 1);

    assign last = (cur == TOP);

    // Clear to 0 (with wrapped neighbours) or step all three taps together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            cur  <= '0;
            nxt  <= '0;
        end else if (clr) begin
            prev <= TOP;
            cur  <= '0;
            nxt  <= coord_t'(1);
        end else if (inc) begin
            prev <= cur;
            cur  <= nxt;
            nxt  <= (nxt == TOP) ? '0 : nxt + coord_t'(1);
        end
    end

endmodule

// File: rtl/theta_apply_controller.sv
// Keccak theta apply: A[x][y] ^= C[x-1] ^ ROTL(C[x+1],1) over all 25 lanes.
// Read stage fetches the lane and builds D; write stage one cycle later.
module theta_apply_controller
    import theta_pkg::*;
#(
    parameter int LANE_W = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        par_addr_a,
    output logic [2:0]        par_addr_b,
    input  logic [LANE_W-1:0] par_data_a,
    input  logic [LANE_W-1:0] par_data_b,
    output logic [2:0]        st_rd_x,
    output logic [2:0]        st_rd_y,
    output logic              st_rd_en,
    input  logic [LANE_W-1:0] st_rd_data,
    output logic              st_wr_en,
    output logic [2:0]        st_wr_x,
    output logic [2:0]        st_wr_y,
    output logic [LANE_W-1:0] st_wr_data
);

    state_t state;

    coord_t x_prev, x_cur, x_next;
    coord_t y_prev, y_cur, y_next;
    logic   x_last, y_last;
    logic   cnt_clr, y_inc, x_inc;

    logic [LANE_MAX-1:0] rot_full;
    logic [LANE_W-1:0]   d_next;

    logic [LANE_W-1:0] d_q;
    coord_t            wr_x_q, wr_y_q;
    logic              wr_valid_q;

    logic unused_y_taps;
    assign unused_y_taps = ^{y_prev, y_next};

    assign cnt_clr = (state == ST_INIT);
    assign y_inc   = (state == ST_RUN);
    assign x_inc   = (state == ST_RUN) && y_last;

    counter5 u_x (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (x_inc),
        .prev (x_prev),
        .cur  (x_cur),
        .nxt  (x_next),
        .last (x_last)
    );

    counter5 u_y (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (y_inc),
        .prev (y_prev),
        .cur  (y_cur),
        .nxt  (y_next),
        .last (y_last)
    );

    assign par_addr_a = x_prev;
    assign par_addr_b = x_next;
    assign st_rd_x    = x_cur;
    assign st_rd_y    = y_cur;

    assign rot_full = rotl1(LANE_MAX'(par_data_b), LANE_W);
    assign d_next   = par_data_a ^ rot_full[LANE_W-1:0];

    assign st_wr_en   = wr_valid_q;
    assign st_wr_x    = wr_x_q;
    assign st_wr_y    = wr_y_q;
    assign st_wr_data = wr_valid_q ? (st_rd_data ^ d_q) : '0;

    // Sweep sequencer with registered busy/done/read-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            st_rd_en <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_INIT;
                        busy  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    state    <= ST_RUN;
                    st_rd_en <= 1'b1;
                end
                ST_RUN: begin
                    if (x_last && y_last) begin
                        state    <= ST_DRAIN;
                        st_rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    st_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Carry D and the lane coordinate alongside the synchronous read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q        <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            wr_valid_q <= (state == ST_RUN);
            if (state == ST_RUN) begin
                d_q    <= d_next;
                wr_x_q <= x_cur;
                wr_y_q <= y_cur;
            end
        end
    end

endmodule

// File: tb/tb_theta_apply_controller.sv
// Bench for theta_apply_controller: 64-bit and 8-bit instances in lockstep.
// Timeline model for per-cycle outputs, lane-level theta model for memory.
module tb_theta_apply_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ld_go = 1'b0;

    always #5 clk = ~clk;

    logic        busy64, done64, re64, we64;
    logic [2:0]  pa64, pb64, rx64, ry64, wx64, wy64;
    logic [63:0] da64, db64, rd64, wd64;

    logic        busy8, done8, re8, we8;
    logic [2:0]  pa8, pb8, rx8, ry8, wx8, wy8;
    logic [7:0]  da8, db8, rd8, wd8;

    logic [63:0] mem64 [25];
    logic [63:0] init64 [25];
    logic [63:0] c64 [5];
    logic [7:0]  mem8 [25];
    logic [7:0]  init8 [25];
    logic [7:0]  c8 [5];

    int tests = 0;
    int fails = 0;

    int n = -1;
    int swr = 0;
    int tw = 0;
    int dn = 0;

    theta_apply_controller #(.LANE_W(64)) u64 (
        .clk(clk), .rst(rst), .start(start), .busy(busy64), .done(done64),
        .par_addr_a(pa64), .par_addr_b(pb64),
        .par_data_a(da64), .par_data_b(db64),
        .st_rd_x(rx64), .st_rd_y(ry64), .st_rd_en(re64), .st_rd_data(rd64),
        .st_wr_en(we64), .st_wr_x(wx64), .st_wr_y(wy64), .st_wr_data(wd64)
    );

    theta_apply_controller #(.LANE_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .busy(busy8), .done(done8),
        .par_addr_a(pa8), .par_addr_b(pb8),
        .par_data_a(da8), .par_data_b(db8),
        .st_rd_x(rx8), .st_rd_y(ry8), .st_rd_en(re8), .st_rd_data(rd8),
        .st_wr_en(we8), .st_wr_x(wx8), .st_wr_y(wy8), .st_wr_data(wd8)
    );

    assign da64 = (pa64 < 3'd5) ? c64[pa64] : 64'd0;
    assign db64 = (pb64 < 3'd5) ? c64[pb64] : 64'd0;
    assign da8  = (pa8 < 3'd5) ? c8[pa8] : 8'd0;
    assign db8  = (pb8 < 3'd5) ? c8[pb8] : 8'd0;

    // State memories: bulk load, 1 sync read + 1 write per cycle.
    always @(posedge clk) begin
        if (ld_go) begin
            for (int i = 0; i < 25; i++) begin
                mem64[i] <= init64[i];
                mem8[i]  <= init8[i];
            end
        end else begin
            if (re64) rd64 <= mem64[rx64 * 5 + ry64];
            if (we64) mem64[wx64 * 5 + wy64] <= wd64;
            if (re8) rd8 <= mem8[rx8 * 5 + ry8];
            if (we8) mem8[wx8 * 5 + wy8] <= wd8;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timeline: n = edges since the edge that sampled start (-1 = idle).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n   <= -1;
            swr <= 0;
        end else begin
            if (we64) swr <= swr + 1;
            if (n >= 0) n <= (n == 27) ? -1 : n + 1;
            else if (start) begin
                n   <= 0;
                swr <= 0;
            end
            tw <= tw + (we64 ? 1 : 0);
            dn <= dn + (done64 ? 1 : 0);
        end
    end

    // Per-cycle output check against the timeline.
    always @(negedge clk) begin
        if (!rst) begin
            int lane, x, y;
            chk("busy", busy64, (n >= 0 && n <= 26));
            chk("done", done64, (n == 27));
            chk("rd_en", re64, (n >= 1 && n <= 25));
            chk("wr_en", we64, (n >= 2 && n <= 26));
            chk("busy8", busy8, (n >= 0 && n <= 26));
            chk("done8", done8, (n == 27));
            chk("wr_en8", we8, (n >= 2 && n <= 26));
            if (n >= 1 && n <= 25) begin
                lane = n - 1;
                x = lane / 5;
                y = lane % 5;
                chk("rd_x", rx64, x);
                chk("rd_y", ry64, y);
                chk("par_a", pa64, (x + 4) % 5);
                chk("par_b", pb64, (x + 1) % 5);
            end
            if (n >= 2 && n <= 26) begin
                lane = n - 2;
                chk("wr_x", wx64, lane / 5);
                chk("wr_y", wy64, lane % 5);
            end
            if (n == 27) chk("sweep_writes", swr, 25);
        end
    end

    function automatic logic [63:0] rotw(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return ((v << 1) & mask) | ((v >> (w - 1)) & 64'd1);
    endfunction

    task automatic check_mem(input string tag);
        logic [63:0] e64, r8;
        logic [7:0]  e8;
        int x;
        for (int i = 0; i < 25; i++) begin
            x = i / 5;
            e64 = init64[i] ^ c64[(x + 4) % 5] ^ rotw(c64[(x + 1) % 5], 64);
            r8  = rotw(64'(c8[(x + 1) % 5]), 8);
            e8  = init8[i] ^ c8[(x + 4) % 5] ^ r8[7:0];
            chk({tag, "_m64"}, mem64[i], e64);
            chk({tag, "_m8"}, mem8[i], e8);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy64, 0);
        chk({tag, "_done"}, done64, 0);
        chk({tag, "_wr_en"}, we64, 0);
        chk({tag, "_rd_en"}, re64, 0);
        chk({tag, "_addrs"}, {pa64, pb64, rx64, ry64, wx64, wy64}, 0);
        chk({tag, "_wdata"}, wd64, 0);
        chk({tag, "_wr_en8"}, we8, 0);
    endtask

    task automatic load_mem();
        @(posedge clk); #1 ld_go = 1'b1;
        @(posedge clk); #1 ld_go = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done64 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        if (!done64) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_sweep(output int cyc);
        load_mem();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(cyc);
    endtask

    task automatic zero_all();
        for (int i = 0; i < 25; i++) begin
            init64[i] = 64'd0;
            init8[i]  = 8'd0;
        end
        for (int i = 0; i < 5; i++) begin
            c64[i] = 64'd0;
            c8[i]  = 8'd0;
        end
    endtask

    initial begin
        int cyc, base, dbase;
        logic [63:0] e;

        zero_all();
        #1 rst = 1'b1;
        #1 chk_reset("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single C[0]=1 plus start-to-done latency.
        c64[0] = 64'd1;
        c8[0]  = 8'd1;
        run_sweep(cyc);
        chk("done_latency", cyc, 28);
        for (int i = 0; i < 25; i++) begin
            e = (i / 5 == 1) ? 64'd1 : (i / 5 == 4) ? 64'd2 : 64'd0;
            chk("t1_lit64", mem64[i], e);
            chk("t1_lit8", mem8[i], e);
        end
        check_mem("t1");

        // MSB of C[1] wraps into bit 0.
        zero_all();
        c64[1] = 64'h8000_0000_0000_0000;
        c8[1]  = 8'h80;
        run_sweep(cyc);
        chk("t2_x0_64", mem64[0], 64'd1);
        chk("t2_x2_64", mem64[12], 64'h8000_0000_0000_0000);
        chk("t2_x0_8", mem8[3], 8'd1);
        chk("t2_x2_8", mem8[10], 8'h80);
        check_mem("t2");

        // start held 40 cycles: two back-to-back sweeps undo each other.
        for (int i = 0; i < 25; i++) begin
            init64[i] = {$urandom(), $urandom()};
            init8[i]  = 8'($urandom());
        end
        for (int i = 0; i < 5; i++) begin
            c64[i] = {$urandom(), $urandom()};
            c8[i]  = 8'($urandom());
        end
        load_mem();
        base  = tw;
        dbase = dn;
        start = 1'b1;
        repeat (40) @(posedge clk);
        #1 start = 1'b0;
        chk("t4_first_done", dn - dbase, 1);
        wait_done(cyc);
        chk("t4_writes", tw - base, 50);
        chk("t4_dones", dn - dbase, 2);
        for (int i = 0; i < 25; i++) begin
            chk("t4_restore64", mem64[i], init64[i]);
            chk("t4_restore8", mem8[i], init8[i]);
        end

        // Async reset after the 10th write, then a clean sweep.
        load_mem();
        base  = tw;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (tw - base < 10 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_ten_writes", tw - base, 10);
        #1 rst = 1'b1;
        #1 chk_reset("t5");
        @(posedge clk); #1 rst = 1'b0;
        base  = tw;
        dbase = dn;
        run_sweep(cyc);
        chk("t5_writes", tw - base, 25);
        chk("t5_dones", dn - dbase, 1);
        check_mem("t5");

        // Random lanes and parities on both widths.
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < 25; i++) begin
                init64[i] = {$urandom(), $urandom()};
                init8[i]  = 8'($urandom());
            end
            for (int i = 0; i < 5; i++) begin
                c64[i] = {$urandom(), $urandom()};
                c8[i]  = 8'($urandom());
            end
            run_sweep(cyc);
            check_mem("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
